// File: rtl/lpm_latch_sequencer.sv
// Round-robin sequencer that shares one lpm_latch between several requesters,
// driving data/gate/aclr/aset through a setup, strobe and hold sequence.
//
// state  | meaning
// IDLE   | waiting for any req; arbitrates and captures winner's op/data
// SETUP  | one cycle with data stable and all strobes low
// STROBE | latch_gate high for lpm_gate_cycles cycles (load / reserved op)
// CTRL   | latch_aclr or latch_aset high for one cycle (clear / set op)
// HOLD   | strobes low, data stable for lpm_hold_cycles cycles
// DONE   | ack pulse to the winner; pointer moves to the winner
module lpm_latch_sequencer #(
    parameter int lpm_width       = 8,
    parameter int lpm_requesters  = 2,
    parameter int lpm_gate_cycles = 1,
    parameter int lpm_hold_cycles = 1
) (
    input  logic                                 clock,
    input  logic                                 sclr,
    input  logic [lpm_requesters-1:0]            req,
    input  logic [2*lpm_requesters-1:0]          req_op,
    input  logic [lpm_requesters*lpm_width-1:0]  req_data,
    output logic [lpm_requesters-1:0]            gnt,
    output logic [lpm_requesters-1:0]            ack,
    output logic [lpm_width-1:0]                 latch_data,
    output logic                                 latch_gate,
    output logic                                 latch_aclr,
    output logic                                 latch_aset,
    output logic                                 busy
);

    localparam int N  = lpm_requesters;
    localparam int W  = lpm_width;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] GATE_LOAD = 4'(lpm_gate_cycles - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(lpm_hold_cycles - 1);
    localparam bit         HAS_HOLD  = (lpm_hold_cycles != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_CTRL, S_HOLD, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   data_q, data_d;
    logic           gate_q, gate_d;
    logic           aclr_q, aclr_d;
    logic           aset_q, aset_d;
    logic           busy_q, busy_d;

    logic [PW-1:0]  scan_idx;
    logic [PW-1:0]  pick_idx;
    logic           pick_valid;
    logic [1:0]     pick_op;
    logic           op_is_ctrl;

    // First requesting index scanning upward from the slot after the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            scan_idx = PW'((int'(ptr_q) + i) % N);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_op    = req_op[2*int'(pick_idx) +: 2];
    assign op_is_ctrl = (op_q == 2'b01) || (op_q == 2'b10);

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (pick_valid) state_d = S_SETUP;
            S_SETUP: begin
                if (op_is_ctrl) begin
                    state_d = S_CTRL;
                end else begin
                    state_d = S_STROBE;
                    cnt_d   = GATE_LOAD;
                end
            end
            S_STROBE, S_CTRL: begin
                if (state_q == S_STROBE && cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (HAS_HOLD) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_HOLD: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every pin comes from a flop.
    always_comb begin
        gnt_d  = gnt_q;
        data_d = data_q;
        op_d   = op_q;
        win_d  = win_q;
        ptr_d  = ptr_q;
        ack_d  = '0;
        gate_d = (state_d == S_STROBE);
        aclr_d = (state_d == S_CTRL) && (op_q == 2'b01);
        aset_d = (state_d == S_CTRL) && (op_q == 2'b10);
        busy_d = (state_d != S_IDLE);
        if (state_q == S_IDLE && pick_valid) begin
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            win_d           = pick_idx;
            op_d            = pick_op;
            if (pick_op != 2'b01 && pick_op != 2'b10) begin
                data_d = req_data[int'(pick_idx)*W +: W];
            end
        end
        if (state_q == S_DONE) begin
            gnt_d = '0;
            ptr_d = win_q;
        end
        if (state_d == S_DONE) ack_d[win_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            gnt_q  <= '0;
            ack_q  <= '0;
            data_q <= '0;
            op_q   <= '0;
            win_q  <= '0;
            ptr_q  <= PW'(N - 1);
            gate_q <= 1'b0;
            aclr_q <= 1'b0;
            aset_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            ack_q  <= ack_d;
            data_q <= data_d;
            op_q   <= op_d;
            win_q  <= win_d;
            ptr_q  <= ptr_d;
            gate_q <= gate_d;
            aclr_q <= aclr_d;
            aset_q <= aset_d;
            busy_q <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign latch_data = data_q;
    assign latch_gate = gate_q;
    assign latch_aclr = aclr_q;
    assign latch_aset = aset_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lpm_latch_sequencer.sv
// Randomized bench for lpm_latch_sequencer: three parameter sets share one clock
// and reset; each is compared every cycle against a latency-based timeline model.
module tb_lpm_latch_sequencer;

    localparam int NI   = 3;
    localparam int CN [NI] = '{2, 3, 1};
    localparam int CW [NI] = '{8, 8, 12};
    localparam int CG [NI] = '{1, 3, 15};
    localparam int CH [NI] = '{1, 0, 15};
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    logic [7:0]  req_v [NI];
    logic [1:0]  op_v  [NI][8];
    logic [15:0] dat_v [NI][8];

    logic [1:0]  req0;  logic [3:0] op0;  logic [15:0] rd0;
    logic [2:0]  req1;  logic [5:0] op1;  logic [23:0] rd1;
    logic [0:0]  req2;  logic [1:0] op2;  logic [11:0] rd2;

    logic [1:0]  gnt0, ack0;  logic [7:0]  ld0;  logic gate0, aclr0, aset0, busy0;
    logic [2:0]  gnt1, ack1;  logic [7:0]  ld1;  logic gate1, aclr1, aset1, busy1;
    logic [0:0]  gnt2, ack2;  logic [11:0] ld2;  logic gate2, aclr2, aset2, busy2;

    always_comb begin
        req0 = req_v[0][1:0];
        op0  = {op_v[0][1], op_v[0][0]};
        rd0  = {dat_v[0][1][7:0], dat_v[0][0][7:0]};
        req1 = req_v[1][2:0];
        op1  = {op_v[1][2], op_v[1][1], op_v[1][0]};
        rd1  = {dat_v[1][2][7:0], dat_v[1][1][7:0], dat_v[1][0][7:0]};
        req2 = req_v[2][0:0];
        op2  = op_v[2][0];
        rd2  = dat_v[2][0][11:0];
    end

    lpm_latch_sequencer #(.lpm_width(8), .lpm_requesters(2), .lpm_gate_cycles(1), .lpm_hold_cycles(1)) u_dut0 (
        .clock(clk), .sclr(sclr), .req(req0), .req_op(op0), .req_data(rd0),
        .gnt(gnt0), .ack(ack0), .latch_data(ld0), .latch_gate(gate0),
        .latch_aclr(aclr0), .latch_aset(aset0), .busy(busy0));

    lpm_latch_sequencer #(.lpm_width(8), .lpm_requesters(3), .lpm_gate_cycles(3), .lpm_hold_cycles(0)) u_dut1 (
        .clock(clk), .sclr(sclr), .req(req1), .req_op(op1), .req_data(rd1),
        .gnt(gnt1), .ack(ack1), .latch_data(ld1), .latch_gate(gate1),
        .latch_aclr(aclr1), .latch_aset(aset1), .busy(busy1));

    lpm_latch_sequencer #(.lpm_width(12), .lpm_requesters(1), .lpm_gate_cycles(15), .lpm_hold_cycles(15)) u_dut2 (
        .clock(clk), .sclr(sclr), .req(req2), .req_op(op2), .req_data(rd2),
        .gnt(gnt2), .ack(ack2), .latch_data(ld2), .latch_gate(gate2),
        .latch_aclr(aclr2), .latch_aset(aset2), .busy(busy2));

    logic [7:0]  o_gnt [NI];
    logic [7:0]  o_ack [NI];
    logic [15:0] o_ld  [NI];
    logic        o_gate [NI], o_aclr [NI], o_aset [NI], o_busy [NI];

    always_comb begin
        o_gnt[0] = 8'(gnt0);  o_ack[0] = 8'(ack0);  o_ld[0] = 16'(ld0);
        o_gnt[1] = 8'(gnt1);  o_ack[1] = 8'(ack1);  o_ld[1] = 16'(ld1);
        o_gnt[2] = 8'(gnt2);  o_ack[2] = 8'(ack2);  o_ld[2] = 16'(ld2);
        o_gate[0] = gate0;  o_aclr[0] = aclr0;  o_aset[0] = aset0;  o_busy[0] = busy0;
        o_gate[1] = gate1;  o_aclr[1] = aclr1;  o_aset[1] = aset1;  o_busy[1] = busy1;
        o_gate[2] = gate2;  o_aclr[2] = aclr2;  o_aset[2] = aset2;  o_busy[2] = busy2;
    end

    // Reference: one in-flight op per instance, described by its sample edge and ack cycle.
    bit          m_act  [NI];
    int          m_t    [NI];
    int          m_ackc [NI];
    int          m_w    [NI];
    int          m_op   [NI];
    int          m_ptr  [NI];
    logic [15:0] m_data [NI];

    int cyc;
    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc + 1, got, exp);
        end
    endtask

    function automatic bit is_load(input int op);
        return (op != 1) && (op != 2);
    endfunction

    task automatic model_edge(input int k);
        int  idx;
        bit  found;
        if (sclr) begin
            m_act[k]  = 1'b0;
            m_ptr[k]  = CN[k] - 1;
            m_data[k] = '0;
            return;
        end
        if (m_act[k] && cyc > m_ackc[k]) begin
            m_act[k] = 1'b0;
            m_ptr[k] = m_w[k];
        end
        if (!m_act[k]) begin
            found = 1'b0;
            for (int j = 1; j <= CN[k]; j++) begin
                idx = (m_ptr[k] + j) % CN[k];
                if (!found && req_v[k][idx]) begin
                    found    = 1'b1;
                    m_act[k] = 1'b1;
                    m_t[k]   = cyc;
                    m_w[k]   = idx;
                    m_op[k]  = int'(op_v[k][idx]);
                    if (is_load(m_op[k])) begin
                        m_data[k] = dat_v[k][idx];
                        m_ackc[k] = cyc + 2 + CG[k] + CH[k];
                    end else begin
                        m_ackc[k] = cyc + 3 + CH[k];
                    end
                end
            end
        end
    endtask

    task automatic check_out(input int k);
        int         c;
        int         d;
        bit         inop;
        logic [7:0] eg;
        c    = cyc + 1;
        d    = c - m_t[k];
        inop = m_act[k] && (d >= 1) && (c <= m_ackc[k]);
        eg   = inop ? 8'(1 << m_w[k]) : 8'h00;
        chk($sformatf("i%0d.gnt", k),  32'(o_gnt[k]), 32'(eg));
        chk($sformatf("i%0d.ack", k),  32'(o_ack[k]), (inop && c == m_ackc[k]) ? 32'(eg) : 32'h0);
        chk($sformatf("i%0d.busy", k), 32'(o_busy[k]), 32'(inop));
        chk($sformatf("i%0d.gate", k), 32'(o_gate[k]),
            32'(inop && is_load(m_op[k]) && d >= 2 && d <= 1 + CG[k]));
        chk($sformatf("i%0d.aclr", k), 32'(o_aclr[k]), 32'(inop && m_op[k] == 1 && d == 2));
        chk($sformatf("i%0d.aset", k), 32'(o_aset[k]), 32'(inop && m_op[k] == 2 && d == 2));
        chk($sformatf("i%0d.data", k), 32'(o_ld[k]), 32'(m_data[k]));
    endtask

    task automatic new_req(input int k, input int i);
        logic [15:0] msk;
        msk         = 16'((32'd1 << CW[k]) - 1);
        req_v[k][i] = 1'b1;
        op_v[k][i]  = 2'($urandom_range(3, 0));
        dat_v[k][i] = 16'($urandom) & msk;
    endtask

    task automatic drive();
        int c;
        int rate;
        bit cur;
        logic [15:0] msk;
        c    = cyc + 1;
        rate = (cyc < NCYC / 2) ? 60 : 10;
        sclr = ($urandom_range(299, 0) == 0);
        for (int k = 0; k < NI; k++) begin
            msk = 16'((32'd1 << CW[k]) - 1);
            for (int i = 0; i < CN[k]; i++) begin
                cur = m_act[k] && (m_w[k] == i) && (c <= m_ackc[k]);
                if (cur && c == m_ackc[k]) begin
                    if ($urandom_range(1, 0) == 1) new_req(k, i);
                    else                           req_v[k][i] = 1'b0;
                end else if (cur) begin
                    if ($urandom_range(7, 0) == 0) req_v[k][i] = 1'b0;
                    if ($urandom_range(1, 0) == 1) begin
                        op_v[k][i]  = 2'($urandom_range(3, 0));
                        dat_v[k][i] = 16'($urandom) & msk;
                    end
                end else if (!req_v[k][i]) begin
                    if ($urandom_range(99, 0) < rate) new_req(k, i);
                end
            end
        end
    endtask

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        sclr  = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_v[k]  = '0;
            m_act[k]  = 1'b0;
            m_t[k]    = 0;
            m_ackc[k] = 0;
            m_w[k]    = 0;
            m_op[k]   = 0;
            m_ptr[k]  = CN[k] - 1;
            m_data[k] = '0;
            for (int i = 0; i < 8; i++) begin
                op_v[k][i]  = '0;
                dat_v[k][i] = '0;
            end
        end
        for (int s = 0; s < NCYC; s++) begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) model_edge(k);
            #1;
            for (int k = 0; k < NI; k++) check_out(k);
            if (cyc < 3) begin
                sclr = 1'b1;
            end else begin
                drive();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
